io_axil_arbiter: RTL and testbench
==================================

# io_axil_arbiter

Two-requester arbiter and sequencer for the core's 4-bit-address AXI4-Lite IO master port. It accepts single-word read/write requests from two clients: requester 0 is the core load/store unit, requester 1 is the debug/boot loader. It grants them round-robin and drives one AXI4-Lite transaction at a time to completion. Each response is returned to the granted requester. It sits between the requesters and the ARADDR/AWADDR/WDATA/… pins of the core top.

## Interface
- ADDR_W, 4, AXI address width (ARADDR/AWADDR, per-requester address slice)
- DATA_W, 32, data width (WDATA/RDATA, per-requester data slice); WSTRB width = DATA_W/8
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ_VALID  in  2  bit n: requester n has a request; held with REQ_* stable until REQ_ACK[n]
- REQ_WE  in  2  bit n: 1 = write, 0 = read
- REQ_ADDR  in  2*ADDR_W  requester n at [n*ADDR_W +: ADDR_W]
- REQ_WDATA  in  2*DATA_W  requester n at [n*DATA_W +: DATA_W]
- REQ_WSTRB  in  2*DATA_W/8  requester n slice; ignored for reads
- REQ_ACK  out  2  one-cycle pulse, request of n captured this cycle (combinational from state/REQ_VALID)
- REQ_DONE  out  2  one-cycle registered pulse, transaction of n complete; RSP_* valid
- RSP_RDATA  out  DATA_W  read data of last completed read; holds until next read completes
- RSP_RESP  out  2  BRESP/RRESP of last completed transaction
- AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out — standard AXI4-Lite master, widths ADDR_W/DATA_W/DATA_W/8/2

## Operation
- States: IDLE, WR (address/data phase), WR_B, RD_A, RD_R, DONE. Reset → IDLE.
- IDLE: if any REQ_VALID, grant g. If both are valid, g = requester ≠ last_grant. last_grant resets to 1, so requester 0 wins the first tie.
- On grant (IDLE):
  - Assert REQ_ACK[g].
  - Latch addr/wdata/wstrb/we into internal registers; set last_grant = g.
  - Go to WR if we, else RD_A.
- WR:
  - AWVALID and WVALID are both high on entry.
  - Each drops independently the cycle after its own VALID&READY handshake.
  - aw_done/w_done flags record completion; when both are set (same cycle allowed) → WR_B.
- WR_B: BREADY=1. On BVALID, capture BRESP into RSP_RESP → DONE.
- RD_A: ARVALID=1. On ARREADY → RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA→RSP_RDATA and RRESP→RSP_RESP → DONE.
- DONE: REQ_DONE[g]=1 for one cycle → IDLE.
- Only one outstanding transaction. No new grant until the DONE cycle has passed.
- RESP values (OKAY/SLVERR/DECERR) are passed through unmodified, and erroring transactions complete normally.
- BVALID/RVALID arriving while BREADY/RREADY is low is ignored; the slave holds them per protocol.
- AxADDR/WDATA/WSTRB are driven from latched registers and are stable while the corresponding VALID is high. A requester deasserting REQ_VALID after ACK has no effect.
- REQ_VALID dropped before ACK is never served. No combinational path from any AXI input to any AXI output.

## Timing
- Reset (RST_N low, asynchronous):
  - AWVALID, WVALID, ARVALID, BREADY, RREADY, REQ_DONE = 0.
  - AWADDR/ARADDR/WDATA/WSTRB, RSP_RDATA, RSP_RESP = 0.
  - State IDLE, flags clear.
- Reset mid-transaction aborts it: no REQ_DONE, all AXI valids drop immediately.
- Zero-wait write: ACK cycle 0; AWVALID/WVALID cycle 1 (READY high); BREADY cycle 2 with BVALID; REQ_DONE cycle 3; next ACK possible cycle 4.
- Zero-wait read: ACK 0, ARVALID 1, RREADY 2, REQ_DONE 3.
- Each extra READY/VALID wait cycle adds exactly one cycle.
- AW and W may complete in different cycles; WR_B is entered the cycle after the later handshake.

## Test plan
- Single write, req0 addr 0x4 data 0xDEADBEEF strb 0xF, slave zero-wait → AW/W on cycle 1 with those values; REQ_DONE=01 on cycle 3; RSP_RESP=00.
- Single read, req1 addr 0xC, slave returns 0x12345678 RRESP=00 after 3 RVALID wait cycles → RREADY held 4 cycles; REQ_DONE=10; RSP_RDATA=0x12345678.
- Both valid continuously, 4 transactions → grant order 0,1,0,1; exactly one ACK and one DONE per transaction; never two outstanding.
- Write with AWREADY delayed 2 cycles and WREADY immediate → WVALID drops after cycle 1; AWVALID drops after cycle 3; BREADY first on cycle 4.
- Read with RRESP=10 (SLVERR) → REQ_DONE pulses; RSP_RESP=10; next request is served normally.
- RST_N low during WR_B → all AXI valids/readies 0 asynchronously; no REQ_DONE; after release, a req0 read is granted with last_grant=1.

Source files
------------

// File: rtl/io_axil_arbiter.sv
// Two-requester round-robin arbiter driving one AXI4-Lite master transaction at a time.
// Requester 0 is the load/store unit, requester 1 the debug/boot loader.
module io_axil_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid_i,
   input  logic [1:0]             req_we_i,
   input  logic [2*ADDR_W-1:0]    req_addr_i,
   input  logic [2*DATA_W-1:0]    req_wdata_i,
   input  logic [2*DATA_W/8-1:0]  req_wstrb_i,
   output logic [1:0]             req_ack_o,
   output logic [1:0]             req_done_o,
   output logic [DATA_W-1:0]      rsp_rdata_o,
   output logic [1:0]             rsp_resp_o,
   output logic [ADDR_W-1:0]      awaddr_o,
   output logic                   awvalid_o,
   input  logic                   awready_i,
   output logic [DATA_W-1:0]      wdata_o,
   output logic [DATA_W/8-1:0]    wstrb_o,
   output logic                   wvalid_o,
   input  logic                   wready_i,
   input  logic [1:0]             bresp_i,
   input  logic                   bvalid_i,
   output logic                   bready_o,
   output logic [ADDR_W-1:0]      araddr_o,
   output logic                   arvalid_o,
   input  logic                   arready_i,
   input  logic [DATA_W-1:0]      rdata_i,
   input  logic [1:0]             rresp_i,
   input  logic                   rvalid_i,
   output logic                   rready_o
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_DONE
   } state_e;

   state_e              state_q;
   logic                last_grant_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
   logic                aw_done_q, w_done_q;
   logic [1:0]          req_done_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic [1:0]          rsp_resp_q;

   logic                grant_valid, grant_idx;
   logic                aw_done_d, w_done_d;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [STRB_W-1:0]   sel_wstrb;
   logic                sel_we;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      if (state_q == S_IDLE && |req_valid_i) begin
         grant_valid = 1'b1;
         // On a tie the requester that did not win last time goes first.
         grant_idx   = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
      end
   end

   assign req_ack_o = {grant_valid & grant_idx, grant_valid & ~grant_idx};

   assign sel_addr  = grant_idx ? req_addr_i[ADDR_W +: ADDR_W]  : req_addr_i[0 +: ADDR_W];
   assign sel_wdata = grant_idx ? req_wdata_i[DATA_W +: DATA_W] : req_wdata_i[0 +: DATA_W];
   assign sel_wstrb = grant_idx ? req_wstrb_i[STRB_W +: STRB_W] : req_wstrb_i[0 +: STRB_W];
   assign sel_we    = grant_idx ? req_we_i[1] : req_we_i[0];

   // A channel counts as finished once it has handshaken now or in an earlier cycle.
   assign aw_done_d = aw_done_q | (awvalid_q & awready_i);
   assign w_done_d  = w_done_q  | (wvalid_q  & wready_i);

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of its peers regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         bready_q     <= 1'b0;
         rready_q     <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         req_done_q   <= 2'b00;
         rsp_rdata_q  <= '0;
         rsp_resp_q   <= 2'b00;
      end else begin
         req_done_q <= 2'b00;
         case (state_q)
            S_IDLE: begin
               if (grant_valid) begin
                  last_grant_q <= grant_idx;
                  addr_q       <= sel_addr;
                  wdata_q      <= sel_wdata;
                  wstrb_q      <= sel_wstrb;
                  if (sel_we) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WR;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= S_RD_A;
                  end
               end
            end
            S_WR: begin
               if (awvalid_q && awready_i) awvalid_q <= 1'b0;
               if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
               if (aw_done_d && w_done_d) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= S_WR_B;
               end else begin
                  aw_done_q <= aw_done_d;
                  w_done_q  <= w_done_d;
               end
            end
            S_WR_B: begin
               if (bvalid_i) begin
                  rsp_resp_q <= bresp_i;
                  bready_q   <= 1'b0;
                  req_done_q <= {last_grant_q, ~last_grant_q};
                  state_q    <= S_DONE;
               end
            end
            S_RD_A: begin
               if (arready_i) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_R;
               end
            end
            S_RD_R: begin
               if (rvalid_i) begin
                  rsp_rdata_q <= rdata_i;
                  rsp_resp_q  <= rresp_i;
                  rready_q    <= 1'b0;
                  req_done_q  <= {last_grant_q, ~last_grant_q};
                  state_q     <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign awaddr_o    = addr_q;
   assign araddr_o    = addr_q;
   assign wdata_o     = wdata_q;
   assign wstrb_o     = wstrb_q;
   assign awvalid_o   = awvalid_q;
   assign wvalid_o    = wvalid_q;
   assign arvalid_o   = arvalid_q;
   assign bready_o    = bready_q;
   assign rready_o    = rready_q;
   assign req_done_o  = req_done_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_resp_o  = rsp_resp_q;

endmodule

// File: tb/tb_io_axil_arbiter.sv
// Directed bench for io_axil_arbiter: per-scenario tasks with a cycle-stepped AXI slave
// whose wait states are set per transaction.
module tb_io_axil_arbiter;

   logic        clk, rst_n;
   logic [1:0]  req_valid_i, req_we_i;
   logic [7:0]  req_addr_i;
   logic [63:0] req_wdata_i;
   logic [7:0]  req_wstrb_i;
   logic [1:0]  req_ack_o, req_done_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_resp_o;
   logic [3:0]  awaddr_o, araddr_o;
   logic        awvalid_o, awready_i, wvalid_o, wready_i;
   logic [31:0] wdata_o, rdata_i;
   logic [3:0]  wstrb_o;
   logic [1:0]  bresp_i, rresp_i;
   logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

   int tests_run, tests_failed;

   // Transaction trace, cycle numbers relative to the ACK cycle (0).
   int          ack_cyc, done_cyc, n_ack, n_done;
   int          aw_first, aw_last, w_first, w_last, ar_first, b_first, r_first, r_cnt;
   logic [1:0]  ack_val, done_val, done_resp;
   logic [31:0] done_rdata, w_data;
   logic [3:0]  aw_addr, ar_addr, w_strb;

   io_axil_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .req_ack_o(req_ack_o), .req_done_o(req_done_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
      .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
      .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at posedge+1 with the request(s) already presented; returns at posedge+1
   // of the cycle after REQ_DONE.
   task automatic run_txn(input int aw_w, input int w_w, input int b_w, input int ar_w,
                          input int r_w, input logic [1:0] resp, input logic [31:0] rd,
                          input bit keep);
      int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
      ack_cyc = -1; done_cyc = -1; n_ack = 0; n_done = 0;
      aw_first = -1; aw_last = -1; w_first = -1; w_last = -1;
      ar_first = -1; b_first = -1; r_first = -1; r_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         awready_i = awvalid_o && (aw_c >= aw_w);
         wready_i  = wvalid_o  && (w_c  >= w_w);
         arready_i = arvalid_o && (ar_c >= ar_w);
         bvalid_i  = bready_o  && (b_c  >= b_w);
         bresp_i   = bvalid_i ? resp : 2'b00;
         rvalid_i  = rready_o  && (r_c  >= r_w);
         rresp_i   = rvalid_i ? resp : 2'b00;
         rdata_i   = rvalid_i ? rd : 32'h0;
         @(negedge clk);
         if (req_ack_o != 2'b00) begin
            n_ack++;
            if (ack_cyc < 0) begin ack_cyc = c; ack_val = req_ack_o; end
         end
         if (awvalid_o) begin
            if (aw_first < 0) begin aw_first = c; aw_addr = awaddr_o; end
            aw_last = c;
         end
         if (wvalid_o) begin
            if (w_first < 0) begin w_first = c; w_data = wdata_o; w_strb = wstrb_o; end
            w_last = c;
         end
         if (arvalid_o && ar_first < 0) begin ar_first = c; ar_addr = araddr_o; end
         if (bready_o && b_first < 0) b_first = c;
         if (rready_o) begin r_cnt++; if (r_first < 0) r_first = c; end
         if (req_done_o != 2'b00) begin
            n_done++; done_cyc = c; done_val = req_done_o;
            done_resp = rsp_resp_o; done_rdata = rsp_rdata_o;
         end
         if (awvalid_o && !awready_i) aw_c++;
         if (wvalid_o && !wready_i)   w_c++;
         if (arvalid_o && !arready_i) ar_c++;
         if (bready_o && !bvalid_i)   b_c++;
         if (rready_o && !rvalid_i)   r_c++;
         @(posedge clk); #1;
         if (c == ack_cyc && !keep) req_valid_i = req_valid_i & ~ack_val;
         if (done_cyc >= 0) break;
      end
      awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
      bvalid_i = 1'b0; rvalid_i = 1'b0;
      if (done_cyc < 0) begin
         tests_run++; tests_failed++;
         $display("FAIL txn_timeout: got no REQ_DONE within 40 cycles, want one");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid_i = 2'b00; req_we_i = 2'b00; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
      awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0; bvalid_i = 1'b0; rvalid_i = 1'b0;
      bresp_i = 2'b00; rresp_i = 2'b00; rdata_i = '0;
      #3;
      tests_run++; if ({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o} !== 5'b0) begin tests_failed++; $display("FAIL rst_valids: got %b want 00000", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}); end
      tests_run++; if ({req_ack_o, req_done_o} !== 4'b0) begin tests_failed++; $display("FAIL rst_ack_done: got %b want 0000", {req_ack_o, req_done_o}); end
      tests_run++; if ({awaddr_o, araddr_o, wstrb_o, wdata_o} !== 44'h0) begin tests_failed++; $display("FAIL rst_axi_payload: got %h want 0", {awaddr_o, araddr_o, wstrb_o, wdata_o}); end
      tests_run++; if ({rsp_rdata_o, rsp_resp_o} !== 34'h0) begin tests_failed++; $display("FAIL rst_rsp: got %h want 0", {rsp_rdata_o, rsp_resp_o}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_write();
      req_addr_i = {4'hA, 4'h4}; req_wdata_i = {32'h5555_5555, 32'hDEAD_BEEF};
      req_wstrb_i = {4'h1, 4'hF}; req_we_i = 2'b11; req_valid_i = 2'b01;
      run_txn(0, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
      tests_run++; if (ack_val !== 2'b01 || ack_cyc !== 0) begin tests_failed++; $display("FAIL wr_ack: got %b@%0d want 01@0", ack_val, ack_cyc); end
      tests_run++; if (aw_first !== 1 || w_first !== 1 || aw_last !== 1 || w_last !== 1) begin tests_failed++; $display("FAIL wr_aw_w_cycle: got aw %0d-%0d w %0d-%0d want 1-1", aw_first, aw_last, w_first, w_last); end
      tests_run++; if ({aw_addr, w_data, w_strb} !== {4'h4, 32'hDEAD_BEEF, 4'hF}) begin tests_failed++; $display("FAIL wr_payload: got %h %h %h want 4 deadbeef f", aw_addr, w_data, w_strb); end
      tests_run++; if (b_first !== 2) begin tests_failed++; $display("FAIL wr_bready: got %0d want 2", b_first); end
      tests_run++; if (done_val !== 2'b01 || done_cyc !== 3 || n_done !== 1) begin tests_failed++; $display("FAIL wr_done: got %b@%0d x%0d want 01@3 x1", done_val, done_cyc, n_done); end
      tests_run++; if (done_resp !== 2'b00) begin tests_failed++; $display("FAIL wr_resp: got %b want 00", done_resp); end
   endtask

   task automatic test_single_read();
      req_addr_i = {4'hC, 4'h3}; req_we_i = 2'b01; req_valid_i = 2'b10;
      run_txn(0, 0, 0, 0, 3, 2'b00, 32'h1234_5678, 1'b0);
      tests_run++; if (ack_val !== 2'b10 || ack_cyc !== 0) begin tests_failed++; $display("FAIL rd_ack: got %b@%0d want 10@0", ack_val, ack_cyc); end
      tests_run++; if (ar_first !== 1 || ar_addr !== 4'hC) begin tests_failed++; $display("FAIL rd_ar: got %h@%0d want c@1", ar_addr, ar_first); end
      tests_run++; if (r_first !== 2 || r_cnt !== 4) begin tests_failed++; $display("FAIL rd_rready: got first %0d len %0d want 2 len 4", r_first, r_cnt); end
      tests_run++; if (done_val !== 2'b10 || done_cyc !== 6) begin tests_failed++; $display("FAIL rd_done: got %b@%0d want 10@6", done_val, done_cyc); end
      tests_run++; if (done_rdata !== 32'h1234_5678 || done_resp !== 2'b00) begin tests_failed++; $display("FAIL rd_data: got %h/%b want 12345678/00", done_rdata, done_resp); end
      tests_run++; if (aw_first !== -1) begin tests_failed++; $display("FAIL rd_no_aw: got awvalid@%0d want none", aw_first); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      req_addr_i = {4'h2, 4'h1}; req_wdata_i = {32'h0, 32'h1111_1111}; req_wstrb_i = 8'hFF;
      req_we_i = 2'b01; req_valid_i = 2'b11;
      for (int t = 0; t < 4; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         run_txn(0, 0, 0, 0, 0, 2'b00, 32'h0BAD_0000 + t, 1'b1);
         tests_run++; if (ack_val !== exp_g || ack_cyc !== 0) begin tests_failed++; $display("FAIL rr_grant%0d: got %b@%0d want %b@0", t, ack_val, ack_cyc, exp_g); end
         tests_run++; if (n_ack !== 1 || n_done !== 1 || done_val !== exp_g || done_cyc !== 3) begin tests_failed++; $display("FAIL rr_one_txn%0d: got acks %0d dones %0d done %b@%0d want 1 1 %b@3", t, n_ack, n_done, done_val, done_cyc, exp_g); end
      end
      req_valid_i = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_aw_delay();
      req_addr_i = {4'h9, 4'h7}; req_wdata_i = {32'h0, 32'hA5A5_0F0F}; req_wstrb_i = {4'hF, 4'h3};
      req_we_i = 2'b01; req_valid_i = 2'b01;
      run_txn(2, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
      tests_run++; if (w_first !== 1 || w_last !== 1) begin tests_failed++; $display("FAIL awd_wvalid: got %0d-%0d want 1-1", w_first, w_last); end
      tests_run++; if (aw_first !== 1 || aw_last !== 3 || aw_addr !== 4'h7) begin tests_failed++; $display("FAIL awd_awvalid: got %0d-%0d addr %h want 1-3 addr 7", aw_first, aw_last, aw_addr); end
      tests_run++; if (b_first !== 4 || done_cyc !== 5 || w_strb !== 4'h3) begin tests_failed++; $display("FAIL awd_b_done: got bready %0d done %0d strb %h want 4 5 3", b_first, done_cyc, w_strb); end
   endtask

   task automatic test_slverr();
      req_addr_i = {4'h6, 4'h3}; req_wdata_i = {32'h7777_0000, 32'h0}; req_wstrb_i = {4'hC, 4'h0};
      req_we_i = 2'b10; req_valid_i = 2'b01;
      run_txn(0, 0, 0, 0, 0, 2'b10, 32'hCAFE_F00D, 1'b0);
      tests_run++; if (done_val !== 2'b01 || done_resp !== 2'b10) begin tests_failed++; $display("FAIL err_rd: got done %b resp %b want 01 10", done_val, done_resp); end
      tests_run++; if (done_rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL err_rdata: got %h want cafef00d", done_rdata); end
      req_valid_i = 2'b10;
      run_txn(0, 1, 1, 0, 0, 2'b00, 32'h0, 1'b0);
      tests_run++; if (done_val !== 2'b10 || done_resp !== 2'b00 || done_cyc !== 5) begin tests_failed++; $display("FAIL err_next: got done %b resp %b @%0d want 10 00 @5", done_val, done_resp, done_cyc); end
      tests_run++; if (done_rdata !== 32'hCAFE_F00D || w_data !== 32'h7777_0000) begin tests_failed++; $display("FAIL err_hold: got rdata %h wdata %h want cafef00d 77770000", done_rdata, w_data); end
   endtask

   task automatic test_reset_mid();
      logic saw_done;
      saw_done = 1'b0;
      req_addr_i = {4'h1, 4'h8}; req_we_i = 2'b01; req_valid_i = 2'b01;
      @(negedge clk);
      tests_run++; if (req_ack_o !== 2'b01) begin tests_failed++; $display("FAIL mid_ack: got %b want 01", req_ack_o); end
      @(posedge clk); #1; req_valid_i = 2'b00; awready_i = 1'b1; wready_i = 1'b1;
      @(negedge clk);
      @(posedge clk); #1; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
      @(negedge clk);
      tests_run++; if (bready_o !== 1'b1) begin tests_failed++; $display("FAIL mid_wr_b: got bready %b want 1", bready_o); end
      #1 rst_n = 1'b0; #1;
      tests_run++; if ({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o} !== 5'b0) begin tests_failed++; $display("FAIL mid_async: got %b want 00000", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}); end
      repeat (2) begin @(posedge clk); #1; if (req_done_o != 2'b00) saw_done = 1'b1; end
      @(negedge clk); rst_n = 1'b1;
      tests_run++; if (saw_done !== 1'b0 || req_done_o !== 2'b00) begin tests_failed++; $display("FAIL mid_no_done: got done pulse %b want 0", saw_done); end
      @(posedge clk); #1;
      req_addr_i = {4'h6, 4'h5}; req_we_i = 2'b10; req_valid_i = 2'b11;
      run_txn(0, 0, 0, 0, 0, 2'b00, 32'h0000_00A5, 1'b0);
      req_valid_i = 2'b00;
      tests_run++; if (ack_val !== 2'b01 || ar_addr !== 4'h5) begin tests_failed++; $display("FAIL mid_regrant: got ack %b araddr %h want 01 5", ack_val, ar_addr); end
      tests_run++; if (done_val !== 2'b01 || done_rdata !== 32'h0000_00A5) begin tests_failed++; $display("FAIL mid_rd_done: got %b %h want 01 000000a5", done_val, done_rdata); end
      @(posedge clk); #1;
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      test_reset();
      test_single_write();
      test_single_read();
      test_round_robin();
      test_aw_delay();
      test_slverr();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
